// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared store-size encodings, store FSM states and latency limit
package mips_mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Highest memory read latency the store unit's counter can cover.
    localparam int RL_MAX = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } store_state_t;

    // True when a request cannot be performed at this address: reserved
    // size, halfword on an odd byte, or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            SZ_HALF: bad = addr[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_size_if.sv
// rtl/store_size_if.sv - store request handshake and word-memory port bundle
// Signals: start/store_size/addr/wdata request in, busy/done/misaligned status out,
// mem_addr/mem_wr/mem_wdata write port out, mem_rdata read data in.
// slave = store unit side, master = control unit / memory side.
interface store_size_if;
    logic        start;
    logic [1:0]  store_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        misaligned;

    modport slave (
        input  start, store_size, addr, wdata, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, busy, done, misaligned
    );

    modport master (
        output start, store_size, addr, wdata, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, busy, done, misaligned
    );
endinterface

// File: rtl/store_merge.sv
// rtl/store_merge.sv - combinational little-endian lane insert of a store operand into a word
// Ports: old_word (word read from memory), wdata (store operand), size (store size),
// lane (addr[1:0]), merged (old_word with the addressed lane(s) replaced).
import mips_mem_pkg::*;

module store_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (size)
            SZ_HALF: begin
                // lane[0] is ignored: a halfword always starts on an even lane
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            SZ_BYTE: begin
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/store_size_unit.sv
// rtl/store_size_unit.sv - word/halfword/byte store to a 32-bit word memory via read-modify-write
// Ports: clk, reset (async active-low), bus (store_size_if.slave: request, status, memory port).
// Parameter READ_LATENCY (1..RL_MAX): cycles from mem_addr to valid mem_rdata.
// Option STORE_SIZE_MISALIGN_CHECK_EN: when defined, misaligned/reserved requests are
// rejected with a misaligned pulse; otherwise low address bits are ignored and the
// reserved size behaves as a word store.
import mips_mem_pkg::*;

module store_size_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    store_size_if.slave  bus
);

    localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);

    store_state_t state, state_nx;
    logic [31:0]  addr_q;
    logic [1:0]   size_q;
    logic [31:0]  wdata_q;
    logic [31:0]  wout_q;
    logic [1:0]   lat_cnt;
    logic [31:0]  merged;
    logic         bad;
    logic         sub_word;
    logic         accept;

`ifdef STORE_SIZE_MISALIGN_CHECK_EN
    assign bad            = is_misaligned(bus.store_size, bus.addr);
    assign bus.misaligned = (state == ST_ERR);
`else
    assign bad            = 1'b0;
    assign bus.misaligned = 1'b0;
`endif

    assign sub_word = (bus.store_size == SZ_HALF) || (bus.store_size == SZ_BYTE);
    assign accept   = (state == ST_IDLE) && bus.start;

    store_merge u_merge (
        .old_word (bus.mem_rdata),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .merged   (merged)
    );

    // Reset is asynchronous so a store caught in WR never completes its write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bad)           state_nx = ST_ERR;
                    else if (sub_word) state_nx = ST_RD;
                    else               state_nx = ST_WR;
                end
            end
            ST_RD:    if (lat_cnt == LAT_LAST) state_nx = ST_MERGE;
            ST_MERGE: state_nx = ST_WR;
            ST_WR:    state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            ST_ERR:   state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            size_q  <= SZ_WORD;
            wdata_q <= '0;
            wout_q  <= '0;
            lat_cnt <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.addr;
                size_q  <= bus.store_size;
                wdata_q <= bus.wdata;
                // Full-word stores skip the read, so the write word is loaded now.
                if (!bad && !sub_word) wout_q <= bus.wdata;
            end
            if (state == ST_MERGE) wout_q <= merged;
            // RD is only entered from IDLE, so holding zero in IDLE clears it on entry.
            if (state == ST_RD) lat_cnt <= lat_cnt + 2'd1;
            else                lat_cnt <= '0;
        end
    end

    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata = wout_q;
    assign bus.mem_wr    = (state == ST_WR);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);

endmodule
